// File: rtl/shade_scheduler.sv
// shade_scheduler: in-order scheduler that shares one shading pipeline between
// NUM_LANES ray-march lanes and streams shaded pixels out as AXI4-Stream video.
//
// Lane k owns pixels k, k+N, k+2N, ... and lanes are granted in strict
// rotation, so results come back in raster order. The shading pipeline cannot
// stall, so a pixel is only issued while the output FIFO has a free slot for it
// (credit = FIFO_DEPTH - fifo_count - in_flight).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start, light_vec   frame start pulse and light direction (latched)
//   lane_valid/hit/normal    per-lane results; lane_ready one-hot grant
//   shade_*                  shading pipeline request / response
//   m_axis_*                 video stream out (tuser = frame start, tlast = end of line)
//   busy, frame_done         status
//
// Optional build macro SHADE_SCHED_STATS_EN adds stall_lane_cnt and
// stall_credit_cnt stall counters.

module shade_scheduler_chk #(
  parameter int CNT_W         = 5,
  parameter int MAX_IN_FLIGHT = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             fifo_wr,
  input logic             fifo_full,
  input logic [CNT_W-1:0] in_flight
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_IN_FLIGHT);

  // A return must never land in a full FIFO; credit accounting prevents it.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));

  // The pipeline holds at most its depth plus the issue register.
  a_in_flight_bound: assert property (@(posedge clk) disable iff (rst) in_flight <= MAX_C);
endmodule

module shade_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int SHADE_LAT   = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480,
  parameter int OUT_WIDTH   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [95:0]              light_vec,
  input  logic [NUM_LANES-1:0]     lane_valid,
  input  logic [NUM_LANES-1:0]     lane_hit,
  input  logic [96*NUM_LANES-1:0]  lane_normal,
  output logic [NUM_LANES-1:0]     lane_ready,
  output logic                     shade_valid_in,
  output logic                     shade_hit_in,
  output logic [95:0]              shade_normal,
  output logic [95:0]              shade_light,
  input  logic [OUT_WIDTH-1:0]     shade_out,
  input  logic                     shade_valid_out,
  output logic [OUT_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic                     busy,
  output logic                     frame_done
`ifdef SHADE_SCHED_STATS_EN
  ,
  output logic [31:0]              stall_lane_cnt,
  output logic [31:0]              stall_credit_cnt
`endif
);
  localparam int TOTAL = LINE_PIXELS * FRAME_LINES;
  localparam int PTR_W = $clog2(NUM_LANES);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ISS_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int X_W   = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int Y_W   = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [ISS_W-1:0] LAST_ISS = ISS_W'(TOTAL - 1);
  localparam logic [X_W-1:0]   LAST_X   = X_W'(LINE_PIXELS - 1);
  localparam logic [Y_W-1:0]   LAST_Y   = Y_W'(FRAME_LINES - 1);

  logic [1:0]           state_r;
  logic [PTR_W-1:0]     ptr_r;
  logic [ISS_W-1:0]     issued_r;
  logic [CNT_W-1:0]     in_flight_r;
  logic [CNT_W-1:0]     fifo_count_r;
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [X_W-1:0]       x_r;
  logic [Y_W-1:0]       y_r;
  logic [95:0]          light_q_r;
  logic                 frame_done_r;

  logic [CNT_W:0]       used_s;
  logic                 credit_ok_s;
  logic                 issue_s;
  logic                 ret_s;
  logic                 rd_s;
  logic                 start_s;

  assign used_s      = {1'b0, fifo_count_r} + {1'b0, in_flight_r};
  assign credit_ok_s = (used_s < DEPTH_W);
  assign start_s     = (state_r == ST_IDLE) && frame_start;
  // Late results arriving in IDLE (e.g. after a mid-frame reset) are discarded.
  assign ret_s       = shade_valid_out && (state_r != ST_IDLE);
  assign rd_s        = m_axis_tvalid && m_axis_tready;
  assign issue_s     = lane_ready[ptr_r] && lane_valid[ptr_r];

  // Grant only the lane at the rotation pointer, and only while a slot is free.
  always_comb begin
    lane_ready = {NUM_LANES{1'b0}};
    if ((state_r == ST_RUN) && credit_ok_s) begin
      lane_ready[ptr_r] = 1'b1;
    end else begin
      lane_ready = {NUM_LANES{1'b0}};
    end
  end

  // Frame FSM, rotation pointer, issue count and light latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= {PTR_W{1'b0}};
      issued_r     <= {ISS_W{1'b0}};
      light_q_r    <= 96'd0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            state_r   <= ST_RUN;
            ptr_r     <= {PTR_W{1'b0}};
            issued_r  <= {ISS_W{1'b0}};
            light_q_r <= light_vec;
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            // NUM_LANES is a power of two, so the pointer wraps naturally.
            ptr_r    <= ptr_r + 1'b1;
            issued_r <= issued_r + 1'b1;
            if (issued_r == LAST_ISS) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((in_flight_r == {CNT_W{1'b0}}) && (fifo_count_r == {CNT_W{1'b0}})) begin
            frame_done_r <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Request register toward the shading pipeline; valid for one cycle per issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      shade_valid_in <= 1'b0;
      shade_hit_in   <= 1'b0;
      shade_normal   <= 96'd0;
    end else begin
      shade_valid_in <= issue_s;
      shade_hit_in   <= issue_s && lane_hit[ptr_r];
      if (issue_s) begin
        shade_normal <= lane_normal[ptr_r*96 +: 96];
      end
    end
  end

  // Pixels issued but not yet returned; saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_r <= {CNT_W{1'b0}};
    end else begin
      case ({issue_s, ret_s})
        2'b10: in_flight_r <= in_flight_r + 1'b1;
        2'b01: begin
          if (in_flight_r != {CNT_W{1'b0}}) begin
            in_flight_r <= in_flight_r - 1'b1;
          end
        end
        default: in_flight_r <= in_flight_r;
      endcase
    end
  end

  // Output FIFO pointers and occupancy; reset discards contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
    end else begin
      if (ret_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({ret_s, rd_s})
        2'b10:   fifo_count_r <= fifo_count_r + 1'b1;
        2'b01:   fifo_count_r <= fifo_count_r - 1'b1;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO storage (no reset needed: occupancy gates every read).
  always_ff @(posedge clk) begin
    if (ret_s) begin
      mem_r[wr_ptr_r] <= shade_out;
    end
  end

  // Output-side raster position, advanced on every accepted beat.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (rd_s) begin
      if (x_r == LAST_X) begin
        x_r <= {X_W{1'b0}};
        y_r <= (y_r == LAST_Y) ? {Y_W{1'b0}} : y_r + 1'b1;
      end else begin
        x_r <= x_r + 1'b1;
      end
    end
  end

  // Stream outputs come straight from the FIFO head and x/y, so they hold while stalled.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = {OUT_WIDTH{1'b0}};
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    if (fifo_count_r != {CNT_W{1'b0}}) begin
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = mem_r[rd_ptr_r];
      m_axis_tuser  = (x_r == {X_W{1'b0}}) && (y_r == {Y_W{1'b0}});
      m_axis_tlast  = (x_r == LAST_X);
    end else begin
      m_axis_tvalid = 1'b0;
    end
  end

  assign shade_light = light_q_r;
  assign busy        = (state_r != ST_IDLE);
  assign frame_done  = frame_done_r;

`ifdef SHADE_SCHED_STATS_EN
  logic [31:0] stall_lane_cnt_r;
  logic [31:0] stall_credit_cnt_r;

  // Stall counters: waiting on the granted lane versus waiting on credit.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      stall_lane_cnt_r   <= 32'd0;
      stall_credit_cnt_r <= 32'd0;
    end else if (state_r == ST_RUN) begin
      if (credit_ok_s && !lane_valid[ptr_r] && (stall_lane_cnt_r != 32'hFFFF_FFFF)) begin
        stall_lane_cnt_r <= stall_lane_cnt_r + 32'd1;
      end
      if (!credit_ok_s && (stall_credit_cnt_r != 32'hFFFF_FFFF)) begin
        stall_credit_cnt_r <= stall_credit_cnt_r + 32'd1;
      end
    end
  end

  assign stall_lane_cnt   = stall_lane_cnt_r;
  assign stall_credit_cnt = stall_credit_cnt_r;
`endif

  shade_scheduler_chk #(
    .CNT_W         (CNT_W),
    .MAX_IN_FLIGHT (SHADE_LAT + 1)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .fifo_wr   (ret_s),
    .fifo_full (fifo_count_r == DEPTH_C),
    .in_flight (in_flight_r)
  );
endmodule

// File: doc/shade_scheduler.md
Name: shade_scheduler

Overview:
In-order scheduler that shares the single shading pipeline between NUM_LANES ray-march lanes.
- Lanes own interleaved pixels: lane k renders pixels k, k+N, k+2N, ...
- The block grants lanes in strict rotation, so results come out in raster order.
- The shading pipeline has no stall input, so the block uses credit-based flow control to keep its output FIFO from overflowing.
- Shaded pixels drain to an AXI4-Stream video master with tuser on frame start and tlast on end of line.

Parameters:
NUM_LANES, 4, number of ray-march lanes (power of 2, 2..8)
SHADE_LAT, 4, fixed shading pipeline latency in cycles (shade_valid_in to shade_valid_out)
FIFO_DEPTH, 16, output FIFO entries (power of 2, >= SHADE_LAT+1)
LINE_PIXELS, 640, pixels per line
FRAME_LINES, 480, lines per frame
OUT_WIDTH, 24, RGB888 pixel width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse that begins a frame
light_vec  in  96  vec3 Q8.24 light direction, sampled at frame_start
lane_valid  in  NUM_LANES  lane k holds a result
lane_hit  in  NUM_LANES  lane k ray hit
lane_normal  in  96*NUM_LANES  vec3 normal of lane k, at bits [96k+95:96k]
lane_ready  out  NUM_LANES  one-hot grant to lane k
shade_valid_in  out  1  to shading valid_in
shade_hit_in  out  1  to shading hit_in
shade_normal  out  96  to shading normal_vec
shade_light  out  96  to shading light_vec
shade_out  in  OUT_WIDTH  from shading shade_out
shade_valid_out  in  1  from shading valid_out
m_axis_tdata  out  OUT_WIDTH  pixel
m_axis_tvalid  out  1
m_axis_tready  in  1
m_axis_tlast  out  1  last pixel of a line
m_axis_tuser  out  1  first pixel of a frame
busy  out  1  high when state is not IDLE
frame_done  out  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset values: all outputs 0; ptr=0; in_flight=0; FIFO empty; issued=0; state IDLE.
- FSM states IDLE, RUN, DRAIN.
  - IDLE: on frame_start, latch light_vec into light_q, clear issued, ptr and x/y counters, and go to RUN.
  - RUN: issue pixels. Go to DRAIN in the cycle the final issue (issued == LINE_PIXELS*FRAME_LINES-1) completes.
  - DRAIN: when in_flight==0, FIFO empty and no beat pending, pulse frame_done for one cycle and go to IDLE.
- frame_start is ignored while busy.
- Credit: credit = FIFO_DEPTH - fifo_count - in_flight, evaluated combinationally from registered counts.
- Grant: lane_ready[k] = (state==RUN) && (ptr==k) && (credit>0), purely combinational. Other lanes always see 0.
- Issue occurs when lane_valid[ptr] && lane_ready[ptr]. On issue:
  - Register shade_valid_in=1, shade_hit_in=lane_hit[ptr], shade_normal=lane_normal[ptr] for the next cycle only.
  - shade_light = light_q, held for the whole frame.
  - ptr wraps NUM_LANES-1 -> 0.
  - issued++ and in_flight++.
- If the lane at ptr is not valid, the block waits on it. It never skips to another lane, even if other lanes are valid.
- in_flight decrements on shade_valid_out. Issue and return in the same cycle leave it unchanged. It saturates at 0.
- shade_valid_out in IDLE is dropped, with no FIFO write and no counter change. This covers stale results after a mid-frame reset.
- FIFO:
  - Write on shade_valid_out (when not in IDLE); read on tvalid && tready.
  - Simultaneous write and read leaves fifo_count unchanged.
  - Overflow is impossible by credit. An assertion flags a write while full.
  - m_axis_tvalid = FIFO non-empty. tdata, tlast and tuser come from the FIFO head and are held stable while tvalid && !tready.
- tuser/tlast are computed on the output side from x/y counters that advance on each accepted beat:
  - tuser = (x==0 && y==0).
  - tlast = (x==LINE_PIXELS-1).
  - x wraps to 0 and y increments; y is cleared at frame end.
- Latency: issue at edge t -> shade_valid_in high in cycle t+1 -> shade_valid_out at t+1+SHADE_LAT -> m_axis_tvalid at t+2+SHADE_LAT.
- Throughput: one pixel per cycle while lanes are valid and tready=1.
- Miss pixels pass through unchanged (0x0000FF from the shading unit).
- Reset mid-frame: everything returns to reset values in the next cycle, and FIFO contents are discarded.

Optional Feature:
Macro SHADE_SCHED_STATS_EN.
- Defined: adds two outputs and their counters:
  - stall_lane_cnt (32): cycles in RUN where credit>0 && !lane_valid[ptr].
  - stall_credit_cnt (32): cycles in RUN where credit==0.
  - Both clear on frame_start accepted and on rst, and saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
Test parameters for scenarios 1-4: NUM_LANES=2, LINE_PIXELS=4, FRAME_LINES=2, FIFO_DEPTH=8, SHADE_LAT=4; shading unit modeled as a 4-cycle delay line with tag=normal.x[7:0].
1. Both lanes always valid, tready=1, frame_start pulse -> 8 beats in pixel order 0..7. tuser on beat 0 only; tlast on beats 3 and 7. First tvalid 6 cycles after the first issue. frame_done exactly once, after beat 7.
2. Lane 1 deasserts lane_valid for 10 cycles -> no lane_ready[0] while ptr=1, no reordering, output order still 0..7.
3. tready=0 for 30 cycles -> at most 8 issues then lane_ready=0, FIFO reaches 8 with no overflow assertion, data held stable. On tready=1 all beats drain in order.
4. frame_start pulsed again during RUN -> ignored, exactly 8 beats. rst asserted at the 5th issue -> all outputs 0 next cycle, later shade_valid_out pulses dropped, new frame runs cleanly.
5. Defaults, lane_hit=0 for all pixels -> every tdata=0x0000FF, 307200 beats, frame_done after the last beat. With SHADE_SCHED_STATS_EN and tready held 0 for 100 cycles after fill, stall_credit_cnt >= 100.
